// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   i_start  request strobe, only honoured while o_busy is low
//   i_op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   i_src1   rs operand: multiplicand, dividend or MTHI/MTLO data
//   i_src2   rt operand: multiplier or divisor
//   o_busy   operation in flight; stall HI/LO readers
//   o_done   one-cycle pulse when HI/LO take a new mul/div result
//   o_hi     HI register (product upper half / remainder)
//   o_lo     LO register (product lower half / quotient)
// master: the requesting stage; slave: the mul/div unit.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
);
    logic             i_start;
    logic [OPW-1:0]   i_op;
    logic [WIDTH-1:0] i_src1;
    logic [WIDTH-1:0] i_src2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_src1, i_src2,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_src1, i_src2,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply/divide unit that owns HI/LO.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (WIDTH CALC steps plus one FIX
// cycle). MTHI/MTLO write HI/LO in a single cycle without going busy.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous reset, active-low
//   bus      alu_muldiv_if slave (start/op/operands in, busy/done/HI/LO out)
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_muldiv_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;   // multiplicand, or divisor
    logic               is_div_q;
    logic               neg_res_q; // negate product / quotient
    logic               neg_rem_q; // remainder follows dividend sign
    logic               div0_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand conditioning at acceptance
    logic               op_signed, op_div, s1_neg, s2_neg;
    logic [WIDTH-1:0]   a_op, b_op;

    // One CALC step
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_r;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] acc_d;

    // FIX-cycle sign correction
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   hi_d, lo_d;

    always_comb begin
        op_signed = ~bus.i_op[0];
        op_div    = bus.i_op[1];
        s1_neg    = op_signed & bus.i_src1[WIDTH-1];
        s2_neg    = op_signed & bus.i_src2[WIDTH-1];
        a_op      = s1_neg ? ('0 - bus.i_src1) : bus.i_src1;
        b_op      = s2_neg ? ('0 - bus.i_src2) : bus.i_src2;
    end

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc LSB) is set, then shift the whole pair right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        // Divide: remainder shifted left with the next dividend bit; the
        // difference fits in WIDTH bits whenever the subtraction is taken.
        div_r   = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge  = div_r >= {1'b0, mcand_q};
        div_sub = div_r[WIDTH-1:0] - mcand_q;
        if (is_div_q) begin
            acc_d = {(div_ge ? div_sub : div_r[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_res_q ? ('0 - acc_q) : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // Divide-by-zero: the restoring loop already leaves the dividend
            // magnitude as remainder, so only the quotient needs forcing.
            lo_d = div0_q ? '1 : (neg_res_q ? ('0 - quo) : quo);
            hi_d = neg_rem_q ? ('0 - rem) : rem;
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        if (!bus.i_op[2]) begin
                            // Multiply: acc low = multiplier; divide: acc low = dividend.
                            acc_q     <= {{WIDTH{1'b0}}, (op_div ? a_op : b_op)};
                            mcand_q   <= op_div ? b_op : a_op;
                            is_div_q  <= op_div;
                            neg_res_q <= s1_neg ^ s2_neg;
                            neg_rem_q <= s1_neg;
                            div0_q    <= op_div & (bus.i_src2 == '0);
                            cnt_q     <= CW'(WIDTH);
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end else if (bus.i_op[1:0] == 2'b00) begin
                            hi_q <= bus.i_src1;
                        end else if (bus.i_op[1:0] == 2'b01) begin
                            lo_q <= bus.i_src1;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed-vector bench for alu_muldiv (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_muldiv;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 3;

    logic        clk;
    logic        rst_n;
    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    alu_muldiv_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_muldiv #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Issue one mul/div op, optionally poke a MULT 2*2 request while busy,
    // then check latency, HI/LO hold during CALC, the result and done pulse.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int unsigned poke_at);
        int unsigned cyc;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_src1  = a;
        bus.i_src2  = b;
        @(negedge clk);
        // Operands may change freely once accepted.
        bus.i_start = 1'b0;
        bus.i_op    = 3'b110;
        bus.i_src1  = 32'hDEADBEEF;
        bus.i_src2  = 32'h0;
        check({tag, "_busy_start"}, 64'(bus.o_busy), 64'd1);
        cyc = 0;
        while (!bus.o_done && cyc < 100) begin
            if (poke_at != 0 && cyc == poke_at) begin
                bus.i_start = 1'b1;
                bus.i_op    = 3'b000;
                bus.i_src1  = 32'd2;
                bus.i_src2  = 32'd2;
            end
            @(negedge clk);
            bus.i_start = 1'b0;
            cyc++;
            if (cyc == WIDTH) begin
                check({tag, "_busy_late"}, 64'(bus.o_busy), 64'd1);
                check({tag, "_hold"}, {bus.o_hi, bus.o_lo}, {prev_hi, prev_lo});
            end
        end
        check({tag, "_latency"}, 64'(cyc), 64'(WIDTH + 1));
        check({tag, "_hi"}, 64'(bus.o_hi), 64'(ehi));
        check({tag, "_lo"}, 64'(bus.o_lo), 64'(elo));
        check({tag, "_busy_end"}, 64'(bus.o_busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_once"}, 64'(bus.o_done), 64'd0);
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    initial begin
        int unsigned done_seen;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_op    = '0;
        bus.i_src1  = '0;
        bus.i_src2  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        check("rst_hi", 64'(bus.o_hi), 64'd0);
        check("rst_lo", 64'(bus.o_lo), 64'd0);
        rst_n   = 1'b1;
        prev_hi = 32'h0;
        prev_lo = 32'h0;

        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg",  3'b000, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mult_nn",   3'b000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 0);
        run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu",      3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       0);
        run_op("divu_zero", 3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0);
        run_op("div_zero",  3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        // MTHI then MTLO on back-to-back cycles.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = 3'b100;
        bus.i_src1  = 32'hA5A5A5A5;
        @(negedge clk);
        check("mthi_hi", 64'(bus.o_hi), 64'hA5A5A5A5);
        check("mthi_lo", 64'(bus.o_lo), 64'h80000000);
        check("mthi_busy", 64'(bus.o_busy), 64'd0);
        bus.i_op   = 3'b101;
        bus.i_src1 = 32'h5A5A5A5A;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("mtlo_lo", 64'(bus.o_lo), 64'h5A5A5A5A);
        check("mtlo_hi", 64'(bus.o_hi), 64'hA5A5A5A5);
        check("mtlo_busy", 64'(bus.o_busy), 64'd0);
        check("mtlo_done", 64'(bus.o_done), 64'd0);
        prev_hi = 32'hA5A5A5A5;
        prev_lo = 32'h5A5A5A5A;

        // Undefined op code is ignored.
        bus.i_start = 1'b1;
        bus.i_op    = 3'b110;
        bus.i_src1  = 32'h12345678;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("op110_busy", 64'(bus.o_busy), 64'd0);
        check("op110_hilo", {bus.o_hi, bus.o_lo}, 64'hA5A5A5A5_5A5A5A5A);
        @(negedge clk);
        check("op110_done", 64'(bus.o_done), 64'd0);

        // Start request while busy must not disturb the running op.
        run_op("busy_poke", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10);

        // Reset in the middle of a DIV.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = 3'b010;
        bus.i_src1  = 32'd1000;
        bus.i_src2  = 32'd7;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (14) @(negedge clk);
        check("rst_mid_busy_pre", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.o_busy), 64'd0);
        check("rst_mid_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_done) done_seen++;
            @(negedge clk);
        end
        check("rst_mid_nodone", 64'(done_seen), 64'd0);
        prev_hi = 32'h0;
        prev_lo = 32'h0;

        run_op("divu_after", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
